// File: rtl/mem_generic_pipe.sv
// -----------------------------------------------------------------------------
// mem_generic_pipe
//
// This is a single-port synchronous RAM with 2^AW words of DW bits. Writes
// complete in one cycle. Reads pass through LAT register stages before they
// reach datr. A read issued at edge N shows on datr at edge N+LAT-1, so LAT=1
// behaves like a classic synchronous RAM.
//
// Parameters:
//   AW   address width (depth = 2^AW words)
//   DW   data width in bits
//   LAT  read latency in clock cycles (legal range 1..8)
//
// Ports:
//   clk   input   clock; all logic runs on the rising edge
//   rstb  input   synchronous reset, ACTIVE-HIGH despite the name
//   add   input   word address
//   datr  output  registered read data; it holds until a new read completes
//   datw  input   write data
//   en    input   access enable
//   we    input   write enable, qualified by en
//
// Access handshake: an access is accepted on every rising edge where
// en=1 and rstb=0. There is no back-pressure, so one access can be
// accepted per cycle. When we=1 the access is a write, otherwise a read.
//
// Optional feature (macro MEM_GENERIC_PIPE_WRITE_THROUGH_EN):
//   When the macro is defined, a write also enters the read pipeline carrying
//   datw, so datr echoes the written value LAT-1 cycles after the write edge.
//   When it is undefined, write cycles leave the read pipeline alone.
//
// The memory array has no reset. Each pipeline stage carries a valid bit.
// Every valid bit and every stage data register clears on reset, so a reset
// discards any read still in flight.
// -----------------------------------------------------------------------------
module mem_generic_pipe #(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic [AW-1:0] add,
   output logic [DW-1:0] datr,
   input  logic [DW-1:0] datw,
   input  logic          en,
   input  logic          we
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];

   logic          wr_fire;
   logic          rd_fire;
   logic          inj_vld;   // a valid entry enters the first stage at this edge
   logic [DW-1:0] inj_dat;
   logic          tail_vld;  // a valid entry reaches the output register
   logic [DW-1:0] tail_dat;
   logic [DW-1:0] datr_q;
   logic [DW-1:0] datr_d;

   // Reset blocks every access at the edge where it is sampled.
   assign wr_fire = en &  we & ~rstb;
   assign rd_fire = en & ~we & ~rstb;

   // Storage array: written in one cycle, never cleared.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[add] <= datw;
      end
   end

`ifdef MEM_GENERIC_PIPE_WRITE_THROUGH_EN
   // Write-first echo: a write enters the read pipeline carrying datw.
   assign inj_vld = rd_fire | wr_fire;
   assign inj_dat = we ? datw : mem_q[add];
`else
   assign inj_vld = rd_fire;
   assign inj_dat = mem_q[add];
`endif

   // Stages 0..LAT-2 sit in front of the output register. datr is the final
   // stage, so LAT=1 needs no extra stages and the array read feeds datr
   // directly.
   if (LAT > 1) begin : g_pipe
      logic [LAT-2:0] vld_q;
      logic [DW-1:0]  dat_q [LAT-1];

      always_ff @(posedge clk) begin
         if (rstb) begin
            vld_q <= '0;
            for (int k = 0; k < LAT-1; k++) begin
               dat_q[k] <= '0;
            end
         end else begin
            vld_q[0] <= inj_vld;
            // A data register loads only when a valid entry arrives. This
            // keeps idle-cycle array reads (possibly X) out of the pipe.
            if (inj_vld) begin
               dat_q[0] <= inj_dat;
            end
            for (int k = 1; k < LAT-1; k++) begin
               vld_q[k] <= vld_q[k-1];
               if (vld_q[k-1]) begin
                  dat_q[k] <= dat_q[k-1];
               end
            end
         end
      end

      assign tail_vld = vld_q[LAT-2];
      assign tail_dat = dat_q[LAT-2];
   end else begin : g_direct
      assign tail_vld = inj_vld;
      assign tail_dat = inj_dat;
   end

   // The output register changes only when a read (or an echo) completes.
   assign datr_d = tail_vld ? tail_dat : datr_q;

   always_ff @(posedge clk) begin
      if (rstb) begin
         datr_q <= '0;
      end else begin
         datr_q <= datr_d;
      end
   end

   assign datr = datr_q;

endmodule

// File: tb/tb_mem_generic_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_generic_pipe
//
// Three instances share one stimulus stream:
//   dut_a  AW=8 DW=8 LAT=1
//   dut_b  AW=8 DW=8 LAT=2
//   dut_c  AW=5 DW=4 LAT=5  (fed from the low bits of add/datw)
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at that same point. Expected values are written out by hand for
// each scenario.
// -----------------------------------------------------------------------------
module tb_mem_generic_pipe;

`ifdef MEM_GENERIC_PIPE_WRITE_THROUGH_EN
   localparam bit WT = 1'b1;
`else
   localparam bit WT = 1'b0;
`endif

   logic       clk;
   logic       rstb;
   logic [7:0] add;
   logic [7:0] datw;
   logic       en;
   logic       we;
   logic [7:0] datr_a;
   logic [7:0] datr_b;
   logic [3:0] datr_c;

   int checks;
   int errors;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_generic_pipe #(.AW(8), .DW(8), .LAT(1)) dut_a (
      .clk(clk), .rstb(rstb), .add(add), .datr(datr_a),
      .datw(datw), .en(en), .we(we)
   );

   mem_generic_pipe #(.AW(8), .DW(8), .LAT(2)) dut_b (
      .clk(clk), .rstb(rstb), .add(add), .datr(datr_b),
      .datw(datw), .en(en), .we(we)
   );

   mem_generic_pipe #(.AW(5), .DW(4), .LAT(5)) dut_c (
      .clk(clk), .rstb(rstb), .add(add[4:0]), .datr(datr_c),
      .datw(datw[3:0]), .en(en), .we(we)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic w, input logic [7:0] a,
                        input logic [7:0] d);
      en   = e;
      we   = w;
      add  = a;
      datw = d;
   endtask

   // ---------------- scenarios ----------------
   // During reset, write attempts must not reach the array, and datr must read 0.
   task automatic test_reset();
      rstb = 1'b1;
      drive(1'b1, 1'b1, 8'd0, 8'hFF);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({datr_a, datr_b, datr_c} !== 20'h0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got a=%h b=%h c=%h exp 0", i, datr_a, datr_b, datr_c);
         end
      end
      rstb = 1'b0;
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({datr_a, datr_b, datr_c} !== 20'h0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got a=%h b=%h c=%h exp 0", i, datr_a, datr_b, datr_c);
         end
      end
   endtask

   // Write add 0..7 with data 11..18, one write every 3 cycles.
   task automatic test_writes();
      logic [7:0] v;
      logic [7:0] ea;
      logic [7:0] eb;
      logic [3:0] ec;
      for (int x = 0; x < 8; x++) begin
         v = 8'(x + 11);
         drive(1'b1, 1'b1, 8'(x), v);
         tick();
         ea = WT ? v : 8'h00;
         eb = WT ? ((x == 0) ? 8'h00 : 8'(v - 8'd1)) : 8'h00;
         checks++;
         if (datr_a !== ea) begin
            errors++;
            $display("FAIL write_edge_a x=%0d got %h exp %h", x, datr_a, ea);
         end
         checks++;
         if (datr_b !== eb) begin
            errors++;
            $display("FAIL write_edge_b x=%0d got %h exp %h", x, datr_b, eb);
         end
         drive(1'b0, 1'b0, 8'd0, 8'd0);
         for (int s = 1; s < 3; s++) begin
            tick();
            checks++;
            if (datr_a !== ea || datr_b !== ea) begin
               errors++;
               $display("FAIL write_idle x=%0d s=%0d got a=%h b=%h exp %h", x, s, datr_a, datr_b, ea);
            end
         end
      end
      for (int i = 0; i < 4; i++) tick();
      ec = WT ? 4'h2 : 4'h0;
      checks++;
      if (datr_c !== ec) begin
         errors++;
         $display("FAIL write_c_after got %h exp %h", datr_c, ec);
      end
   endtask

   // Read add 0..7 with 4 idle cycles after each read. Checks latency and hold.
   task automatic test_spaced_reads();
      logic [7:0] v;
      logic [7:0] prev_b;
      logic [3:0] prev_c;
      logic [3:0] ec;
      prev_b = WT ? 8'd18 : 8'd0;
      prev_c = WT ? 4'h2 : 4'h0;
      for (int x = 0; x < 8; x++) begin
         v = 8'(x + 11);
         drive(1'b1, 1'b0, 8'(x), 8'd0);
         tick();
         checks++;
         if (datr_a !== v) begin
            errors++;
            $display("FAIL spaced_a_edge x=%0d got %h exp %h", x, datr_a, v);
         end
         checks++;
         if (datr_b !== prev_b) begin
            errors++;
            $display("FAIL spaced_b_edge x=%0d got %h exp %h", x, datr_b, prev_b);
         end
         checks++;
         if (datr_c !== prev_c) begin
            errors++;
            $display("FAIL spaced_c_edge x=%0d got %h exp %h", x, datr_c, prev_c);
         end
         drive(1'b0, 1'b0, 8'd0, 8'd0);
         for (int s = 1; s <= 4; s++) begin
            tick();
            ec = (s == 4) ? v[3:0] : prev_c;
            checks++;
            if (datr_a !== v || datr_b !== v) begin
               errors++;
               $display("FAIL spaced_ab_hold x=%0d s=%0d got a=%h b=%h exp %h", x, s, datr_a, datr_b, v);
            end
            checks++;
            if (datr_c !== ec) begin
               errors++;
               $display("FAIL spaced_c x=%0d s=%0d got %h exp %h", x, s, datr_c, ec);
            end
         end
         prev_b = v;
         prev_c = v[3:0];
      end
   endtask

   // 8 reads on consecutive cycles, then drain. Results must come out in order.
   task automatic test_back_to_back();
      logic [7:0] ea;
      logic [7:0] eb;
      logic [7:0] tc;
      logic [3:0] ec;
      for (int k = 0; k < 13; k++) begin
         if (k < 8) drive(1'b1, 1'b0, 8'(k), 8'd0);
         else       drive(1'b0, 1'b0, 8'd0, 8'd0);
         tick();
         ea = (k < 8) ? 8'(k + 11) : 8'd18;
         eb = (k == 0) ? 8'd18 : ((k - 1 < 8) ? 8'(k - 1 + 11) : 8'd18);
         tc = (k < 4) ? 8'd18 : ((k - 4 < 8) ? 8'(k - 4 + 11) : 8'd18);
         ec = tc[3:0];
         checks++;
         if (datr_a !== ea) begin
            errors++;
            $display("FAIL b2b_a k=%0d got %h exp %h", k, datr_a, ea);
         end
         checks++;
         if (datr_b !== eb) begin
            errors++;
            $display("FAIL b2b_b k=%0d got %h exp %h", k, datr_b, eb);
         end
         checks++;
         if (datr_c !== ec) begin
            errors++;
            $display("FAIL b2b_c k=%0d got %h exp %h", k, datr_c, ec);
         end
      end
   endtask

   // Write add 9 = 0x5A, then read it back on the very next cycle.
   task automatic test_read_after_write();
      logic [7:0] ea;
      logic [7:0] eb;
      logic [3:0] ec;
      drive(1'b1, 1'b1, 8'd9, 8'h5A);
      tick();
      ea = WT ? 8'h5A : 8'd18;
      checks++;
      if (datr_a !== ea || datr_b !== 8'd18) begin
         errors++;
         $display("FAIL raw_write_edge got a=%h b=%h exp a=%h b=12", datr_a, datr_b, ea);
      end
      drive(1'b1, 1'b0, 8'd9, 8'd0);
      tick();
      eb = WT ? 8'h5A : 8'd18;
      checks++;
      if (datr_a !== 8'h5A || datr_b !== eb) begin
         errors++;
         $display("FAIL raw_read_edge got a=%h b=%h exp a=5a b=%h", datr_a, datr_b, eb);
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      for (int s = 2; s <= 5; s++) begin
         tick();
         ec = (s == 5) ? 4'hA : ((s == 4) ? (WT ? 4'hA : 4'h2) : 4'h2);
         checks++;
         if (datr_b !== 8'h5A || datr_c !== ec) begin
            errors++;
            $display("FAIL raw_drain s=%0d got b=%h c=%h exp b=5a c=%h", s, datr_b, datr_c, ec);
         end
      end
   endtask

   // Issue a read of add 3, then reset two cycles later. The data for add 3
   // must never show; a write attempted during reset must be dropped.
   task automatic test_reset_midflight();
      drive(1'b1, 1'b0, 8'd3, 8'd0);
      tick();
      checks++;
      if (datr_a !== 8'h0E) begin
         errors++;
         $display("FAIL mid_read_a got %h exp 0e", datr_a);
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      rstb = 1'b1;
      drive(1'b1, 1'b1, 8'd3, 8'h77);
      tick();
      checks++;
      if ({datr_a, datr_b, datr_c} !== 20'h0) begin
         errors++;
         $display("FAIL mid_reset got a=%h b=%h c=%h exp 0", datr_a, datr_b, datr_c);
      end
      rstb = 1'b0;
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({datr_a, datr_b, datr_c} !== 20'h0) begin
            errors++;
            $display("FAIL mid_no_stale i=%0d got a=%h b=%h c=%h exp 0", i, datr_a, datr_b, datr_c);
         end
      end
      // add 3 must still hold 14 (0x0E), not the 0x77 attempted during reset.
      drive(1'b1, 1'b0, 8'd3, 8'd0);
      tick();
      checks++;
      if (datr_a !== 8'h0E || datr_b !== 8'h00) begin
         errors++;
         $display("FAIL mid_reread_edge got a=%h b=%h exp a=0e b=00", datr_a, datr_b);
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      checks++;
      if (datr_b !== 8'h0E) begin
         errors++;
         $display("FAIL mid_reread_b got %h exp 0e", datr_b);
      end
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (datr_c !== 4'hE) begin
         errors++;
         $display("FAIL mid_reread_c got %h exp e", datr_c);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks = 0;
      errors = 0;
      rstb   = 1'b1;
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      test_reset();
      test_writes();
      test_spaced_reads();
      test_back_to_back();
      test_read_after_write();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
